reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the CPU datapath: configurable width, depth and read-port count, two write ports, clocked storage with synchronous reset, registered reads with same-cycle write bypass, and a per-register pending-write scoreboard. It replaces the single-write-port, unclocked register array. Decode reads operands through it, and the ALU and load writeback paths write results through it.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never pending

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  RD_PORTS*ADDR_W  read addresses; port k uses slice k
- rd_data  out  RD_PORTS*DATA_W  registered read data, port k in slice k
- rd_busy  out  RD_PORTS  registered pending flag for the addressed register
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback)
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (load writeback)
- issue_en, issue_addr  in  1/ADDR_W  mark a register pending (long-latency op issued)

## Operation
- Storage: 2**ADDR_W × DATA_W flops. At each edge with rst=0, weN=1 writes wdN to waN.
- Write collision: we0 and we1 both set, wa0==wa1. Port 1 value is stored and bypassed.
- Any write to a register clears its pending bit.
- issue_en=1 sets the pending bit of issue_addr.
- Issue and write to the same address in the same cycle: the bit is set. Issue wins, because it is a newer producer.
- ZERO_REG=1: address 0 writes and issues are ignored. rd_data is 0 and rd_busy is 0 for address 0.
- Read port k, sampled each edge:
  - rd_data[k] ← the post-edge content of rd_addr[k]. This is a write-first bypass: a same-edge write to that address returns the new wd, with the port-1 priority above.
  - rd_busy[k] ← the post-edge pending bit for that address.
- No read-port conflicts. Every port may address the same register.

## Timing
- Read latency is 1 cycle. An address presented in cycle t gives data and busy valid after edge t and held through cycle t+1.
- Write latency is 1 edge. A value written at edge t is visible on every port sampled at edge t or later.
- Reset at any edge:
  - all registers ← 0
  - all pending bits ← 0
  - rd_data ← 0, rd_busy ← 0
  - writes and issues in that cycle are discarded
- Reset mid-operation needs no recovery sequence. The first non-reset edge behaves normally.
- No combinational path from inputs to outputs.

## Structure
- Package regfile_pkg holds:
  - constants REG_DATA_W=32, REG_ADDR_W=5, REG_RD_PORTS=2
  - typedefs reg_addr_t and reg_data_t used by decode and writeback
- Sub-module reg_scoreboard holds:
  - the 2**ADDR_W pending-bit vector
  - set/clear logic: set on issue, clear on either write, set wins
  - one registered busy output per read port
- Data array, write-priority mux and bypass stay in reg_file_mp.

## Test plan
- Reset, then read all 32 addresses on both ports → every rd_data=0, rd_busy=0. Write 0xDEADBEEF to r5, then reset → r5 reads 0.
- Write r7=0x12345678 while rd_addr0=7 in the same cycle → rd_data0=0x12345678 the next cycle (bypass). Write r0=0xFFFFFFFF → r0 reads 0.
- we0: r3=0xAAAA0000 and we1: r3=0x0000BBBB in the same cycle → next read of r3 = 0x0000BBBB. Distinct addresses r3/r4 → both values stored.
- issue r9 → rd_busy=1 for r9 from the next read. we1 writes r9=0x55 → busy 0 and data 0x55 together. Issue r9 plus write r9 in the same cycle → busy stays 1 and data is updated.
- RD_PORTS=4, DATA_W=16: four ports read r1, r2, r1, r0 after r1=0x00F1, r2=0x00F2 → outputs 0x00F1, 0x00F2, 0x00F1, 0x0000.
- rst asserted in the same cycle as we0 to r6=0x77 and issue r6 → after release, r6 reads 0 and busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and operand types.
// Decode and writeback import these so widths stay consistent.
package regfile_pkg;

  localparam int REG_DATA_W   = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_RD_PORTS = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register.
// Issue sets the bit, writeback clears it, and issue wins a same-cycle tie.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int RD_PORTS = REG_RD_PORTS,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic [RD_PORTS-1:0]        rd_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [RD_PORTS-1:0] busy_q, busy_d;

  always_comb begin
    pend_d = pend_q;
    if (we0) pend_d[wa0] = 1'b0;
    if (we1) pend_d[wa1] = 1'b0;
    // Issue is the newer producer, so it overrides a same-cycle clear
    if (issue_en) pend_d[issue_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    busy_d = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      busy_d[k] = pend_d[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign rd_busy = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, N registered read ports
// with write-first bypass, and a pending-write scoreboard.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int RD_PORTS = REG_RD_PORTS,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [DATA_W-1:0]          mem_d [DEPTH];
  logic [RD_PORTS*DATA_W-1:0] rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wa0] = wd0;
    // Port 1 (load) is applied last so it wins an address collision
    if (we1) mem_d[wa1] = wd1;
    if (ZERO_REG != 0) mem_d[0] = '0;
    rd_d = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_d[k*DATA_W +: DATA_W] = mem_d[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .RD_PORTS (RD_PORTS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .we0        (we0),
    .wa0        (wa0),
    .we1        (we1),
    .wa1        (wa1),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_busy    (rd_busy)
  );

endmodule
